// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and constants for the serial word feeder and
//                its staging FIFO. Provides the shifter FSM state type, the
//                default word width and a helper that sizes the bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Shifter FSM states. The width is fixed so the encoding is explicit.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default number of bits per parallel word.
    localparam int unsigned c_default_width = 16;

    // Width of a counter that must hold 0 .. width-1 (never less than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : serial_fifo
//  Description : Synchronous DEPTH x WIDTH staging FIFO with a combinational
//                head read port and a synchronous clear.
//  Ports       : clk     - clock, all state changes on posedge
//                rst_n   - asynchronous active-low reset
//                clear   - synchronous clear of pointers and count
//                push    - write wdata at the tail (ignored when full)
//                pop     - drop the head entry (ignored when empty)
//                wdata   - write data
//                rdata   - current head entry (valid when !empty)
//                count   - number of stored entries, 0 .. DEPTH
//                full    - count == DEPTH
//                empty   - count == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_fifo
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: entries are only read once count says so.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : serial_fifo
`default_nettype wire

// File: rtl/serial_word_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_feeder
//  Description : Accepts parallel words over valid/ready, stages them in a
//                small FIFO and shifts each one out a bit per clock with a
//                qualifying valid. Consecutive words leave with no gap.
//  Ports       : clk       - clock, all state changes on posedge
//                rst_n     - asynchronous active-low reset
//                in_data   - parallel input word
//                in_valid  - in_data valid
//                in_ready  - FIFO can accept a word this cycle
//                flush     - synchronous clear of FIFO and shifter
//                bit_out   - serial data, 0 whenever bit_valid is 0
//                bit_valid - bit_out carries a data bit this cycle
//                busy      - FIFO non-empty or shifter active
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = c_default_width,
    parameter int unsigned DEPTH     = 2,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy
);

    localparam int unsigned BCNT_W = cnt_width(WIDTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BCNT_W-1:0] bitcnt_q, bitcnt_d;

    logic [WIDTH-1:0]  shreg_adv;
    logic              head_bit;
    logic              last_bit;
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // No bypass when full: a pop in the same cycle does not open the input.
    assign in_ready = rst_n & ~flush & ~fifo_full;
    assign push     = in_valid & in_ready;

    serial_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The bit on the line is always the shift register's outgoing end.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
            assign head_bit  = shreg_q[0];
        end else begin : g_msb_first
            assign shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
            assign head_bit  = shreg_q[WIDTH-1];
        end
    endgenerate

    assign last_bit = (bitcnt_q == BCNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        pop      = 1'b0;
        if (flush) begin
            state_d  = IDLE;
            shreg_d  = '0;
            bitcnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shreg_d  = fifo_rdata;
                        bitcnt_d = '0;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        shreg_d  = shreg_adv;
                        bitcnt_d = bitcnt_q + BCNT_W'(1);
                    end else if (!fifo_empty) begin
                        // Reload straight from the FIFO head: no idle bit.
                        pop      = 1'b1;
                        shreg_d  = fifo_rdata;
                        bitcnt_d = '0;
                    end else begin
                        shreg_d  = '0;
                        bitcnt_d = '0;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    shreg_d  = '0;
                    bitcnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // All outputs decode directly from flops, so they are glitch-free and
    // fall to 0 the moment reset asserts.
    assign bit_valid = (state_q == SHIFT);
    assign bit_out   = bit_valid & head_bit;
    assign busy      = bit_valid | (fifo_count != '0);

endmodule : serial_word_feeder
`default_nettype wire

// File: tb/tb_serial_word_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_feeder
//  Description : Self-checking bench for serial_word_feeder. Two instances
//                (LSB-first and MSB-first) share the same stimulus and are
//                compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_feeder;

    localparam int W = 16;
    localparam int D = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          l_ready, l_bit, l_valid, l_busy;
    logic          m_ready, m_bit, m_valid, m_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: pending words, the word on the line and its bit index.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_cur = '0;
    int           m_pos = 0;
    bit           m_active = 1'b0;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(W), .DEPTH(D), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_ready), .flush(flush), .bit_out(l_bit),
        .bit_valid(l_valid), .busy(l_busy)
    );

    serial_word_feeder #(.WIDTH(W), .DEPTH(D), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_ready), .flush(flush), .bit_out(m_bit),
        .bit_valid(m_valid), .busy(m_busy)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_pos    = 0;
    endtask

    // One clock edge of the behavioural model.
    task automatic model_edge(input bit v, input bit f, input logic [W-1:0] d);
        bit rdy;
        rdy = !f && (mq.size() < D);
        if (f) begin
            model_reset();
        end else begin
            if (m_active && m_pos < W - 1) begin
                m_pos++;
            end else if (mq.size() > 0) begin
                m_cur    = mq.pop_front();
                m_pos    = 0;
                m_active = 1'b1;
            end else begin
                m_active = 1'b0;
            end
            if (v && rdy) mq.push_back(d);
        end
    endtask

    function automatic logic exp_lsb();
        return m_active ? m_cur[m_pos] : 1'b0;
    endfunction

    function automatic logic exp_msb();
        return m_active ? m_cur[W-1-m_pos] : 1'b0;
    endfunction

    task automatic compare_outputs(input string tag);
        bit eb;
        eb = m_active || (mq.size() > 0);
        check({tag, "_lsb_bit"},   l_bit,   exp_lsb());
        check({tag, "_lsb_valid"}, l_valid, m_active);
        check({tag, "_lsb_busy"},  l_busy,  eb);
        check({tag, "_msb_bit"},   m_bit,   exp_msb());
        check({tag, "_msb_valid"}, m_valid, m_active);
        check({tag, "_msb_busy"},  m_busy,  eb);
    endtask

    // Called at posedge+1: drive inputs, check in_ready, take one edge, check.
    task automatic step(input bit v, input logic [W-1:0] d, input bit f,
                        output bit accepted);
        bit er;
        in_valid = v;
        in_data  = d;
        flush    = f;
        #1;
        er = !f && (mq.size() < D);
        check("ready_lsb", l_ready, er);
        check("ready_msb", m_ready, er);
        accepted = v && l_ready;
        @(posedge clk);
        model_edge(v, f, d);
        #1;
        compare_outputs("model");
    endtask

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           e_bit;
        bit           e_valid;
        bit           e_busy;
    } vec_t;

    initial begin
        vec_t          vec[18];
        logic [15:0]   pat;
        logic [W-1:0]  words[4];
        int            acc_edge[4];
        bit            acc;
        int            k;

        // ---------------- reset state ----------------
        in_valid = 1'b1;
        #1;
        check("rst_bit",   l_bit,   1'b0);
        check("rst_valid", l_valid, 1'b0);
        check("rst_busy",  l_busy,  1'b0);
        check("rst_ready", l_ready, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        step(1'b0, '0, 1'b0, acc);

        // ---------------- single word, LSB first ----------------
        pat = 16'b1101_1111_1010_1110;   // expected bits 1..16 of the stream
        vec[0] = '{v: 1'b1, d: 16'hDFAE, e_bit: 1'b0, e_valid: 1'b0, e_busy: 1'b1};
        for (int i = 1; i <= 16; i++)
            vec[i] = '{v: 1'b0, d: '0, e_bit: pat[i-1], e_valid: 1'b1, e_busy: 1'b1};
        vec[17] = '{v: 1'b0, d: '0, e_bit: 1'b0, e_valid: 1'b0, e_busy: 1'b0};
        for (int i = 0; i < 18; i++) begin
            step(vec[i].v, vec[i].d, 1'b0, acc);
            check("t1_bit",   l_bit,   vec[i].e_bit);
            check("t1_valid", l_valid, vec[i].e_valid);
            check("t1_busy",  l_busy,  vec[i].e_busy);
        end

        // ---------------- back-to-back words ----------------
        step(1'b1, 16'hFFFF, 1'b0, acc);
        for (int i = 0; i < 32; i++) begin
            step(i == 0, 16'h0000, 1'b0, acc);
            check("t2_valid", l_valid, 1'b1);
            check("t2_bit",   l_bit,   (i < 16) ? 1'b1 : 1'b0);
        end
        step(1'b0, '0, 1'b0, acc);
        check("t2_end_valid", l_valid, 1'b0);

        // ---------------- back-pressure, DEPTH=2 ----------------
        words[0] = 16'h1234; words[1] = 16'h5678;
        words[2] = 16'h9ABC; words[3] = 16'hDEF0;
        k = 0;
        for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
            step(1'b1, words[k], 1'b0, acc);
            if (acc) begin
                acc_edge[k] = cyc;
                k++;
            end
        end
        check("t3_all_accepted", k, 4);
        if (k == 4) begin
            check("t3_acc_a", acc_edge[0], 0);
            check("t3_acc_b", acc_edge[1], 1);
            check("t3_acc_c", acc_edge[2], 2);
            // Ready reopens only after the pop at E17 frees a slot.
            check("t3_acc_d", acc_edge[3], 18);
        end
        for (int i = 0; i < 80 && (l_busy || m_busy); i++)
            step(1'b0, '0, 1'b0, acc);
        check("t3_drained", l_busy, 1'b0);

        // ---------------- MSB first ----------------
        step(1'b1, 16'h8001, 1'b0, acc);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b0, acc);
            check("t4_msb_valid", m_valid, 1'b1);
            check("t4_msb_bit",   m_bit,   (i == 0 || i == 15) ? 1'b1 : 1'b0);
        end
        step(1'b0, '0, 1'b0, acc);
        check("t4_msb_end", m_valid, 1'b0);

        // ---------------- mid-word asynchronous reset ----------------
        step(1'b1, 16'hFFFF, 1'b0, acc);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, acc);
        check("t5_pre_valid", l_valid, 1'b1);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_bit",   l_bit,   1'b0);
        check("t5_rst_valid", l_valid, 1'b0);
        check("t5_rst_busy",  l_busy,  1'b0);
        check("t5_rst_ready", l_ready, 1'b0);
        check("t5_rst_mbusy", m_busy,  1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        compare_outputs("t5_after");
        step(1'b1, 16'h0003, 1'b0, acc);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, acc);
            check("t5_bit", l_bit, (i < 2) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 20 && l_busy; i++) step(1'b0, '0, 1'b0, acc);

        // ---------------- mid-word flush with a queued word ----------------
        step(1'b1, 16'hFFFF, 1'b0, acc);
        step(1'b1, 16'h0F0F, 1'b0, acc);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, acc);
        check("t6_pre_busy", l_busy, 1'b1);
        step(1'b0, '0, 1'b1, acc);
        check("t6_fl_valid", l_valid, 1'b0);
        check("t6_fl_busy",  l_busy,  1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b0, acc);
            check("t6_quiet", l_valid, 1'b0);
        end
        step(1'b1, 16'h00F1, 1'b0, acc);
        check("t6_push_valid", l_valid, 1'b0);
        step(1'b0, '0, 1'b0, acc);
        check("t6_lat1_valid", l_valid, 1'b1);
        check("t6_lat1_bit",   l_bit,   1'b1);
        for (int i = 0; i < 20 && l_busy; i++) step(1'b0, '0, 1'b0, acc);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 60, W'($urandom),
                 $urandom_range(0, 99) < 2, acc);
        end
        for (int i = 0; i < 60; i++) step(1'b0, '0, 1'b0, acc);
        check("final_idle", l_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_word_feeder
`default_nettype wire
